// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/redirect path: reset PC, fetch increment,
// the per-instruction prediction tag and the EX-stage mispredict check.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    // Prediction made at fetch time, carried alongside the instruction
    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] ptgt;
    } pred_tag_t;

    // A valid tag mispredicts when the direction is wrong, when a correctly
    // predicted taken branch went somewhere else, or when the predictor
    // claimed a non-branch was taken (aliasing in the target buffer).
    function automatic logic eval_mispredict(
        input pred_tag_t   tag,
        input logic        is_branch,
        input logic        taken,
        input logic [31:0] target
    );
        logic miss;
        miss = 1'b0;
        if (tag.vld) begin
            if (is_branch) begin
                miss = (taken != tag.pred) ||
                       (taken && tag.pred && (target != tag.ptgt));
            end else begin
                miss = tag.pred;
            end
        end
        return miss;
    endfunction

endpackage

// File: rtl/branch_redirect_unit_pred_tag_stage.sv
// One pipeline register for a prediction tag. Flush clears it, hold keeps
// it, bubble empties it; otherwise it loads the upstream tag.
module pred_tag_stage
    import cpu_pkg::*;
(
    input  logic      CLK,
    input  logic      RSTn,
    input  logic      flush,
    input  logic      hold,
    input  logic      bubble,
    input  pred_tag_t d,
    output pred_tag_t q
);

    // Tag register: flush beats hold, hold beats bubble
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: chooses the next PC from the predictor, sequential fetch
// or an EX redirect, tracks each prediction to EX, and drives the flush,
// predictor update and statistics counters.
module branch_redirect_unit #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] PC_INC   = cpu_pkg::PC_INC
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        stall,
    input  logic        predict_IF,
    input  logic [31:0] preaddr,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] PC_now,
    output logic        branch_jump,
    output logic [31:0] PC_happen,
    output logic [31:0] PC_to,
    output logic        predict_EX,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    import cpu_pkg::*;

    pred_tag_t tag_if;
    pred_tag_t tag_id;
    pred_tag_t tag_ex;
    logic      mispredict;

    assign tag_if = '{vld: 1'b1, pc: PC_now, pred: predict_IF, ptgt: preaddr};

    pred_tag_stage u_tag_id (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .flush  (mispredict),
        .hold   (stall),
        .bubble (1'b0),
        .d      (tag_if),
        .q      (tag_id)
    );

    pred_tag_stage u_tag_ex (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .flush  (mispredict),
        .hold   (1'b0),
        .bubble (stall),
        .d      (tag_id),
        .q      (tag_ex)
    );

    // EX resolution and predictor update; everything reads as idle when EX is empty
    always_comb begin
        mispredict  = eval_mispredict(tag_ex, ex_is_branch, ex_taken, ex_target);
        branch_jump = 1'b0;
        PC_happen   = 32'h0;
        PC_to       = 32'h0;
        predict_EX  = 1'b1;
        redirect_pc = 32'h0;
        if (tag_ex.vld) begin
            branch_jump = ex_is_branch;
            PC_happen   = tag_ex.pc;
            PC_to       = ex_target;
            predict_EX  = ~ex_taken;
            redirect_pc = (ex_is_branch && ex_taken) ? ex_target
                                                     : tag_ex.pc + PC_INC;
        end
    end

    assign flush = mispredict;

    // Fetch PC: redirect beats stall, stall beats prediction
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            PC_now <= RESET_PC;
        end else if (mispredict) begin
            PC_now <= redirect_pc;
        end else if (stall) begin
            PC_now <= PC_now;
        end else if (predict_IF) begin
            PC_now <= preaddr;
        end else begin
            PC_now <= PC_now + PC_INC;
        end
    end

    // Resolved-branch and mispredict statistics, free-running and wrapping
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            branch_cnt  <= 32'h0;
            mispred_cnt <= 32'h0;
        end else begin
            if (branch_jump) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: each step queues the outputs it
// expects, drives one cycle of inputs and drains the queue against the DUT.
module tb_branch_redirect_unit;

    logic        CLK;
    logic        RSTn;
    logic        stall;
    logic        predict_IF;
    logic [31:0] preaddr;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] PC_now;
    logic        branch_jump;
    logic [31:0] PC_happen;
    logic [31:0] PC_to;
    logic        predict_EX;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    localparam int S_PC   = 0;
    localparam int S_BJ   = 1;
    localparam int S_FL   = 2;
    localparam int S_PEX  = 3;
    localparam int S_PHAP = 4;
    localparam int S_PTO  = 5;
    localparam int S_RED  = 6;
    localparam int S_BCNT = 7;
    localparam int S_MCNT = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    branch_redirect_unit dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .stall        (stall),
        .predict_IF   (predict_IF),
        .preaddr      (preaddr),
        .ex_is_branch (ex_is_branch),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .PC_now       (PC_now),
        .branch_jump  (branch_jump),
        .PC_happen    (PC_happen),
        .PC_to        (PC_to),
        .predict_EX   (predict_EX),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        case (sel)
            S_PC:   v = PC_now;
            S_BJ:   v = {31'h0, branch_jump};
            S_FL:   v = {31'h0, flush};
            S_PEX:  v = {31'h0, predict_EX};
            S_PHAP: v = PC_happen;
            S_PTO:  v = PC_to;
            S_RED:  v = redirect_pc;
            S_BCNT: v = branch_cnt;
            S_MCNT: v = mispred_cnt;
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic expectVal(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic st, input logic pi, input logic [31:0] pa,
                                 input logic br, input logic tk, input logic [31:0] tg);
        @(negedge CLK);
        stall        = st;
        predict_IF   = pi;
        preaddr      = pa;
        ex_is_branch = br;
        ex_taken     = tk;
        ex_target    = tg;
        #1;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", e.name, obs, e.val);
            end
        end
    endtask

    // Directed sequence
    initial begin
        RSTn = 1'b0;
        stall = 1'b0; predict_IF = 1'b0; preaddr = 32'h0;
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        expectVal("rst_pc", S_PC, 32'h0);
        expectVal("rst_bj", S_BJ, 32'h0);
        expectVal("rst_flush", S_FL, 32'h0);
        expectVal("rst_pex", S_PEX, 32'h1);
        expectVal("rst_phap", S_PHAP, 32'h0);
        expectVal("rst_pto", S_PTO, 32'h0);
        expectVal("rst_red", S_RED, 32'h0);
        expectVal("rst_bcnt", S_BCNT, 32'h0);
        expectVal("rst_mcnt", S_MCNT, 32'h0);
        checkOutput();
        RSTn = 1'b1;
        $display("[TB] reset released");

        expectVal("c0_pc", S_PC, 32'h0);
        expectVal("c0_bj", S_BJ, 32'h0);
        expectVal("c0_flush", S_FL, 32'h0);
        checkOutput();

        expectVal("c1_pc", S_PC, 32'h4);
        expectVal("c1_bj", S_BJ, 32'h0);
        expectVal("c1_flush", S_FL, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c2_pc", S_PC, 32'h8);
        expectVal("c2_flush", S_FL, 32'h0);
        expectVal("c2_phap", S_PHAP, 32'h0);
        applyStimulus(0, 1, 32'h40, 0, 0, 32'h0); checkOutput();

        expectVal("pred_taken_pc", S_PC, 32'h40);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c4_pc", S_PC, 32'h44);
        expectVal("hit_bj", S_BJ, 32'h1);
        expectVal("hit_phap", S_PHAP, 32'h8);
        expectVal("hit_pto", S_PTO, 32'h40);
        expectVal("hit_pex", S_PEX, 32'h0);
        expectVal("hit_flush", S_FL, 32'h0);
        expectVal("hit_bcnt_before", S_BCNT, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h40); checkOutput();

        expectVal("c5_pc", S_PC, 32'h48);
        expectVal("c5_bcnt", S_BCNT, 32'h1);
        expectVal("c5_bj", S_BJ, 32'h0);
        applyStimulus(0, 1, 32'h10, 0, 0, 32'h0); checkOutput();

        expectVal("c6_pc", S_PC, 32'h10);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c7_pc", S_PC, 32'h14);
        expectVal("c7_bj", S_BJ, 32'h1);
        expectVal("c7_phap", S_PHAP, 32'h48);
        expectVal("c7_flush", S_FL, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h10); checkOutput();

        expectVal("c8_pc", S_PC, 32'h18);
        expectVal("nt_miss_flush", S_FL, 32'h1);
        expectVal("nt_miss_red", S_RED, 32'h80);
        expectVal("nt_miss_bj", S_BJ, 32'h1);
        expectVal("nt_miss_pex", S_PEX, 32'h0);
        expectVal("nt_miss_mcnt_before", S_MCNT, 32'h0);
        expectVal("c8_bcnt", S_BCNT, 32'h2);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h80); checkOutput();

        expectVal("redir_pc", S_PC, 32'h80);
        expectVal("redir_mcnt", S_MCNT, 32'h1);
        expectVal("redir_bcnt", S_BCNT, 32'h3);
        expectVal("bubble1_flush", S_FL, 32'h0);
        expectVal("bubble1_bj", S_BJ, 32'h0);
        expectVal("bubble1_phap", S_PHAP, 32'h0);
        expectVal("bubble1_pto", S_PTO, 32'h0);
        expectVal("bubble1_pex", S_PEX, 32'h1);
        expectVal("bubble1_red", S_RED, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h99); checkOutput();

        expectVal("c10_pc", S_PC, 32'h84);
        expectVal("bubble2_bj", S_BJ, 32'h0);
        expectVal("bubble2_flush", S_FL, 32'h0);
        applyStimulus(0, 1, 32'h20, 1, 1, 32'h99); checkOutput();

        expectVal("c11_pc", S_PC, 32'h20);
        applyStimulus(0, 1, 32'h200, 0, 0, 32'h0); checkOutput();

        expectVal("c12_pc", S_PC, 32'h200);
        expectVal("c12_bj", S_BJ, 32'h1);
        expectVal("c12_flush", S_FL, 32'h0);
        expectVal("c12_phap", S_PHAP, 32'h84);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h20); checkOutput();

        expectVal("c13_pc", S_PC, 32'h204);
        expectVal("t_miss_flush", S_FL, 32'h1);
        expectVal("t_miss_red", S_RED, 32'h24);
        expectVal("t_miss_pex", S_PEX, 32'h1);
        expectVal("t_miss_bj", S_BJ, 32'h1);
        expectVal("t_miss_phap", S_PHAP, 32'h20);
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0); checkOutput();

        expectVal("stall_miss_pc", S_PC, 32'h24);
        expectVal("c14_mcnt", S_MCNT, 32'h2);
        expectVal("c14_bcnt", S_BCNT, 32'h5);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c15_pc", S_PC, 32'h28);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c16_pc", S_PC, 32'h2C);
        expectVal("c16_phap", S_PHAP, 32'h24);
        applyStimulus(1, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("stall1_pc", S_PC, 32'h2C);
        expectVal("stall1_bj", S_BJ, 32'h0);
        expectVal("stall1_flush", S_FL, 32'h0);
        applyStimulus(1, 0, 32'h0, 1, 1, 32'h77); checkOutput();

        expectVal("stall2_pc", S_PC, 32'h2C);
        expectVal("stall2_bj", S_BJ, 32'h0);
        expectVal("stall2_flush", S_FL, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h77); checkOutput();

        expectVal("post_stall_pc", S_PC, 32'h30);
        expectVal("held_tag_bj", S_BJ, 32'h1);
        expectVal("held_tag_phap", S_PHAP, 32'h28);
        expectVal("held_tag_pex", S_PEX, 32'h1);
        expectVal("held_tag_flush", S_FL, 32'h0);
        expectVal("c19_bcnt", S_BCNT, 32'h5);
        applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0); checkOutput();

        expectVal("top_pc", S_PC, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("wrap_pc", S_PC, 32'h0);
        expectVal("c21_bj", S_BJ, 32'h1);
        expectVal("c21_flush", S_FL, 32'h0);
        expectVal("c21_phap", S_PHAP, 32'h30);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC); checkOutput();

        expectVal("c22_pc", S_PC, 32'h4);
        expectVal("wrap_red", S_RED, 32'h0);
        expectVal("wrap_phap", S_PHAP, 32'hFFFF_FFFC);
        expectVal("c22_flush", S_FL, 32'h0);
        expectVal("c22_bcnt", S_BCNT, 32'h7);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0); checkOutput();

        expectVal("c23_pc", S_PC, 32'h100);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c24_pc", S_PC, 32'h104);
        expectVal("alias_flush", S_FL, 32'h1);
        expectVal("alias_bj", S_BJ, 32'h0);
        expectVal("alias_red", S_RED, 32'h8);
        expectVal("alias_mcnt_before", S_MCNT, 32'h2);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("alias_pc", S_PC, 32'h8);
        expectVal("alias_mcnt", S_MCNT, 32'h3);
        expectVal("alias_bcnt", S_BCNT, 32'h7);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c26_pc", S_PC, 32'hC);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        expectVal("c27_pc", S_PC, 32'h10);
        expectVal("pre_rst_flush", S_FL, 32'h1);
        expectVal("pre_rst_red", S_RED, 32'h500);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h500); checkOutput();

        #1 RSTn = 1'b0;
        #1;
        expectVal("midrst_pc", S_PC, 32'h0);
        expectVal("midrst_flush", S_FL, 32'h0);
        expectVal("midrst_bj", S_BJ, 32'h0);
        expectVal("midrst_bcnt", S_BCNT, 32'h0);
        expectVal("midrst_mcnt", S_MCNT, 32'h0);
        checkOutput();

        @(negedge CLK);
        #1;
        RSTn = 1'b1;
        expectVal("rel_pc", S_PC, 32'h0);
        expectVal("rel_bj", S_BJ, 32'h0);
        expectVal("rel_flush", S_FL, 32'h0);
        checkOutput();

        expectVal("rel_next_pc", S_PC, 32'h4);
        expectVal("rel_next_flush", S_FL, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0); checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
